// File: rtl/instruction_sequencer_if.sv
// Host/sequencer bus for instruction_sequencer: program load, launch and issued instruction.
// Optional SEQ_STEP_EN adds the step qualifier driven by the host.
interface instruction_sequencer_if #(
    parameter int PC_WIDTH = 5
);
    logic                start;
    logic                prog_we;
    logic [PC_WIDTH-1:0] prog_addr;
    logic [15:0]         prog_data;
`ifdef SEQ_STEP_EN
    logic                step;
`endif
    logic [15:0]         instruction;
    logic [PC_WIDTH-1:0] pc;
    logic                busy;
    logic                done;
    logic                err;

`ifdef SEQ_STEP_EN
    modport master (output start, prog_we, prog_addr, prog_data, step,
                    input  instruction, pc, busy, done, err);
    modport slave  (input  start, prog_we, prog_addr, prog_data, step,
                    output instruction, pc, busy, done, err);
`else
    modport master (output start, prog_we, prog_addr, prog_data,
                    input  instruction, pc, busy, done, err);
    modport slave  (input  start, prog_we, prog_addr, prog_data,
                    output instruction, pc, busy, done, err);
`endif
endinterface

// File: rtl/instruction_sequencer.sv
// Program-memory-driven instruction issuer feeding the TPU top; stretches COMPUTE over the array window.
// Optional feature macro SEQ_STEP_EN: ISSUE only advances on cycles where bus.step is high.
module instruction_sequencer #(
    parameter int IMEM_DEPTH   = 32,
    parameter int PC_WIDTH     = 5,
    parameter int COMPUTE_HOLD = 6
) (
    input  logic                     clk,
    input  logic                     reset,
    instruction_sequencer_if.slave   bus
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_HOLD  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [2:0] OP_COMPUTE = 3'b100;
    localparam logic [2:0] OP_ILLEGAL = 3'b110;
    localparam logic [2:0] OP_HALT    = 3'b111;

    localparam logic [3:0]          HOLD_INIT = 4'(COMPUTE_HOLD - 1);
    localparam logic [PC_WIDTH-1:0] LAST_PC   = PC_WIDTH'(IMEM_DEPTH - 1);

    state_t              state_r;
    logic [PC_WIDTH-1:0] pc_r;
    logic [15:0]         instr_r;
    logic [3:0]          cnt_r;
    logic                busy_r;
    logic                done_r;
    logic                err_r;
    logic                end_r;
    logic [15:0]         imem_r [IMEM_DEPTH];
    logic [15:0]         word_s;
    logic                advance_s;
    logic                wr_ok_s;

`ifdef SEQ_STEP_EN
    assign advance_s = bus.step;
`else
    assign advance_s = 1'b1;
`endif

    assign word_s  = imem_r[pc_r];
    assign wr_ok_s = (state_r == ST_IDLE) || (state_r == ST_DONE);

    // Program memory: not reset so a loaded program survives a reset pulse.
    always_ff @(posedge clk) begin
        if (bus.prog_we && wr_ok_s) begin
            imem_r[bus.prog_addr] <= bus.prog_data;
        end
    end

    // Sequencer FSM with registered outputs; end_r marks that the last word has been issued.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
            pc_r    <= '0;
            instr_r <= 16'h0000;
            cnt_r   <= 4'd0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            err_r   <= 1'b0;
            end_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    instr_r <= 16'h0000;
                    if (bus.start) begin
                        pc_r    <= '0;
                        err_r   <= 1'b0;
                        end_r   <= 1'b0;
                        busy_r  <= 1'b1;
                        done_r  <= 1'b0;
                        state_r <= ST_ISSUE;
                    end else begin
                        state_r <= state_r;
                    end
                end
                ST_ISSUE: begin
                    if (!advance_s) begin
                        instr_r <= 16'h0000;
                    end else if (end_r) begin
                        // Memory exhausted without HALT: finish as if a HALT followed the last word.
                        instr_r <= 16'h0000;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                        state_r <= ST_DONE;
                    end else begin
                        pc_r  <= pc_r + PC_WIDTH'(1);
                        end_r <= (pc_r == LAST_PC);
                        case (word_s[15:13])
                            OP_HALT: begin
                                instr_r <= 16'h0000;
                                busy_r  <= 1'b0;
                                done_r  <= 1'b1;
                                state_r <= ST_DONE;
                            end
                            OP_ILLEGAL: begin
                                instr_r <= 16'h0000;
                                err_r   <= 1'b1;
                            end
                            OP_COMPUTE: begin
                                instr_r <= word_s;
                                if (COMPUTE_HOLD > 1) begin
                                    cnt_r   <= HOLD_INIT;
                                    state_r <= ST_HOLD;
                                end else begin
                                    state_r <= ST_ISSUE;
                                end
                            end
                            default: begin
                                instr_r <= word_s;
                            end
                        endcase
                    end
                end
                ST_HOLD: begin
                    cnt_r <= cnt_r - 4'd1;
                    if (cnt_r == 4'd1) begin
                        state_r <= ST_ISSUE;
                    end else begin
                        state_r <= ST_HOLD;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    instr_r <= 16'h0000;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.instruction = instr_r;
    assign bus.pc          = pc_r;
    assign bus.busy        = busy_r;
    assign bus.done        = done_r;
    assign bus.err         = err_r;
endmodule

// File: tb/tb_instruction_sequencer.sv
// Directed self-checking bench for instruction_sequencer (default build and SEQ_STEP_EN build).
module tb_instruction_sequencer;
    logic clk = 1'b0;
    logic reset;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    instruction_sequencer_if #(.PC_WIDTH(5)) bus ();

    instruction_sequencer #(
        .IMEM_DEPTH  (32),
        .PC_WIDTH    (5),
        .COMPUTE_HOLD(6)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    logic [15:0] full_prog [$] = '{16'h200F, 16'h4000, 16'h201E, 16'h6000,
                                   16'h8000, 16'h2007, 16'hA000, 16'hE000};
    logic [15:0] full_exp  [$] = '{16'h200F, 16'h4000, 16'h201E, 16'h6000,
                                   16'h8000, 16'h8000, 16'h8000, 16'h8000,
                                   16'h8000, 16'h8000, 16'h2007, 16'hA000};
    logic [15:0] step_exp  [$] = '{16'h0000, 16'h0000, 16'h200F, 16'h0000,
                                   16'h0000, 16'h4000, 16'h0000, 16'h0000,
                                   16'h8000, 16'h8000, 16'h8000, 16'h8000,
                                   16'h8000, 16'h8000, 16'h0000};

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input logic [4:0] addr, input logic [15:0] data);
        bus.prog_we   = 1'b1;
        bus.prog_addr = addr;
        bus.prog_data = data;
        tick();
        bus.prog_we   = 1'b0;
    endtask

    task automatic pulse_start(input string tag);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk({tag, "_launch_busy"}, 16'(bus.busy), 16'd1);
        chk({tag, "_launch_instr"}, bus.instruction, 16'h0000);
        chk({tag, "_launch_err"}, 16'(bus.err), 16'd0);
    endtask

    // Runs a launched program and checks every issued cycle, then the DONE cycle.
    task automatic run_expect(input string tag, input logic [15:0] exp[$],
                              input logic inject, input logic [15:0] done_pc);
        for (int i = 0; i < exp.size(); i++) begin
            if (inject && i == 5) begin
                bus.prog_we   = 1'b1;
                bus.prog_addr = 5'd3;
                bus.prog_data = 16'hA000;
                bus.start     = 1'b1;
            end
            tick();
            bus.prog_we = 1'b0;
            bus.start   = 1'b0;
            chk($sformatf("%s_instr%0d", tag, i), bus.instruction, exp[i]);
            chk($sformatf("%s_busy%0d", tag, i), 16'(bus.busy), 16'd1);
        end
        tick();
        chk({tag, "_end_instr"}, bus.instruction, 16'h0000);
        chk({tag, "_end_done"}, 16'(bus.done), 16'd1);
        chk({tag, "_end_busy"}, 16'(bus.busy), 16'd0);
        chk({tag, "_end_pc"}, 16'(bus.pc), done_pc);
    endtask

    initial begin
        reset         = 1'b0;
        bus.start     = 1'b0;
        bus.prog_we   = 1'b0;
        bus.prog_addr = 5'd0;
        bus.prog_data = 16'h0000;
`ifdef SEQ_STEP_EN
        bus.step      = 1'b1;
`endif
        tick();
        tick();
        reset = 1'b1;
        tick();
        chk("rst_instr", bus.instruction, 16'h0000);
        chk("rst_pc", 16'(bus.pc), 16'd0);
        chk("rst_busy", 16'(bus.busy), 16'd0);
        chk("rst_done", 16'(bus.done), 16'd0);
        chk("rst_err", 16'(bus.err), 16'd0);

        // Full program, then rerun with a write and start injected during HOLD.
        for (int i = 0; i < full_prog.size(); i++) write_word(5'(i), full_prog[i]);
        pulse_start("full");
        run_expect("full", full_exp, 1'b0, 16'd8);
        pulse_start("prot");
        run_expect("prot", full_exp, 1'b1, 16'd8);

        // Reset mid-program, then confirm program memory survived.
        pulse_start("mid");
        tick();
        chk("mid_instr0", bus.instruction, 16'h200F);
        tick();
        tick();
        chk("mid_instr2", bus.instruction, 16'h201E);
        reset = 1'b0;
        #1;
        chk("mid_async_instr", bus.instruction, 16'h0000);
        chk("mid_async_busy", 16'(bus.busy), 16'd0);
        tick();
        tick();
        reset = 1'b1;
        tick();
        chk("mid_rst_instr", bus.instruction, 16'h0000);
        chk("mid_rst_pc", 16'(bus.pc), 16'd0);
        chk("mid_rst_busy", 16'(bus.busy), 16'd0);
        chk("mid_rst_done", 16'(bus.done), 16'd0);
        chk("mid_rst_err", 16'(bus.err), 16'd0);
        pulse_start("rerun");
        run_expect("rerun", full_exp, 1'b0, 16'd8);

        // Illegal opcode: dropped, err sticky into DONE, cleared by a new start.
        write_word(5'd0, 16'h200F);
        write_word(5'd1, 16'hC000);
        write_word(5'd2, 16'hA000);
        write_word(5'd3, 16'hE000);
        pulse_start("ill");
        tick();
        chk("ill_i0", bus.instruction, 16'h200F);
        chk("ill_e0", 16'(bus.err), 16'd0);
        tick();
        chk("ill_i1", bus.instruction, 16'h0000);
        chk("ill_e1", 16'(bus.err), 16'd1);
        tick();
        chk("ill_i2", bus.instruction, 16'hA000);
        chk("ill_e2", 16'(bus.err), 16'd1);
        tick();
        chk("ill_i3", bus.instruction, 16'h0000);
        chk("ill_done", 16'(bus.done), 16'd1);
        chk("ill_e3", 16'(bus.err), 16'd1);
        tick();
        chk("ill_e_done", 16'(bus.err), 16'd1);
        pulse_start("ill_clr");
        for (int i = 0; i < 4; i++) tick();
        chk("ill_clr_done", 16'(bus.done), 16'd1);

        // No HALT: every word issued, then DONE with pc wrapped to 0.
        for (int i = 0; i < 32; i++) write_word(5'(i), 16'h2001);
        pulse_start("nohalt");
        for (int i = 0; i < 32; i++) begin
            tick();
            chk($sformatf("nohalt_i%0d", i), bus.instruction, 16'h2001);
        end
        chk("nohalt_pc_wrap", 16'(bus.pc), 16'd0);
        tick();
        chk("nohalt_end_instr", bus.instruction, 16'h0000);
        chk("nohalt_end_done", 16'(bus.done), 16'd1);
        chk("nohalt_end_pc", 16'(bus.pc), 16'd0);

`ifdef SEQ_STEP_EN
        // Step every third cycle; COMPUTE hold ignores step.
        write_word(5'd0, 16'h200F);
        write_word(5'd1, 16'h4000);
        write_word(5'd2, 16'h8000);
        write_word(5'd3, 16'hE000);
        bus.step = 1'b0;
        pulse_start("step");
        for (int k = 1; k <= 15; k++) begin
            bus.step = ((k % 3) == 0);
            tick();
            chk($sformatf("step_i%0d", k), bus.instruction, step_exp[k-1]);
        end
        chk("step_done", 16'(bus.done), 16'd1);
        bus.step = 1'b1;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
